// File: rtl/alu_pkg.sv
// ALU control codes shared by the ALU and the ALU-control decoder.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  // SUB and SLT both run the adder in subtract mode
  function automatic logic uses_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD, SUB and SLT.
module alu_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH:0]   wide;

  // a + b, or a + ~b + 1; overflow when like-signed addends give an unlike-signed sum
  always_comb begin
    bb       = sub ? ~b : b;
    wide     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    sum      = wide[WIDTH-1:0];
    carry    = wide[WIDTH];
    overflow = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/mips_alu.sv
// Registered single-cycle MIPS ALU: logic ops, add/sub/slt, shifts, flags.
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] as_sum;
  logic             as_c, as_v;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_nx;
  logic             c_nx, v_nx;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (a),
    .b        (b),
    .sub      (uses_sub(op)),
    .sum      (as_sum),
    .carry    (as_c),
    .overflow (as_v)
  );

  assign shamt = b[SHW-1:0];

  // next result/flags; flags only meaningful for ADD/SUB, undefined ops give 0
  always_comb begin
    res_nx = '0;
    c_nx   = 1'b0;
    v_nx   = 1'b0;
    case (op)
      OP_AND: res_nx = a & b;
      OP_OR:  res_nx = a | b;
      OP_XOR: res_nx = a ^ b;
      OP_NOR: res_nx = ~(a | b);
      OP_ADD, OP_SUB: begin
        res_nx = as_sum;
        c_nx   = as_c;
        v_nx   = as_v;
      end
      // sign of a-b corrected by overflow gives the true signed compare
      OP_SLT: res_nx = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_v};
      OP_SLL: res_nx = a << shamt;
      OP_SRL: res_nx = a >> shamt;
      OP_SRA: res_nx = WIDTH'($signed(a) >>> shamt);
      default: ;
    endcase
  end

  // output registers: load on valid, hold otherwise; out_valid follows in_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= res_nx;
        zero     <= (res_nx == '0);
        carry    <= c_nx;
        overflow <= v_nx;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu (WIDTH=4): directed plan cases plus random stream with resets.
module tb_mips_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   op = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, overflow, out_valid;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z, c, v, ov;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total = 0, bad = 0;

  mips_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m = '{res: '0, z: 1'b1, c: 1'b0, v: 1'b0, ov: 1'b0};
  endtask

  // reference built from integer arithmetic, independent of the RTL adder
  task automatic model(input logic [3:0] ia, ib, iop, input logic iv);
    int ua, ub, sa, sb, s, sh;
    m.ov = iv;
    if (!iv) return;
    ua = int'(ia); ub = int'(ib);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sh = ub % 4;
    m.c = 1'b0; m.v = 1'b0;
    case (iop)
      4'b0000: s = ua & ub;
      4'b0001: s = ua | ub;
      4'b0011: s = ua ^ ub;
      4'b1100: s = 15 - (ua | ub);
      4'b0010: begin
        s = ua + ub;
        m.c = (s > 15);
        m.v = (sa + sb > 7) || (sa + sb < -8);
      end
      4'b0110: begin
        s = ua + (15 - ub) + 1;
        m.c = (s > 15);
        m.v = (sa - sb > 7) || (sa - sb < -8);
      end
      4'b0111: s = (sa < sb) ? 1 : 0;
      4'b1000: s = ua << sh;
      4'b1001: s = ua >> sh;
      4'b1010: s = sa >>> sh;
      default: s = 0;
    endcase
    m.res = 4'(s & 15);
    m.z   = (m.res == 0);
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".res"}, 32'(result), 32'(e.res));
    chk({tag, ".z"},   32'(zero),   32'(e.z));
    chk({tag, ".c"},   32'(carry),  32'(e.c));
    chk({tag, ".v"},   32'(overflow), 32'(e.v));
    chk({tag, ".ov"},  32'(out_valid), 32'(e.ov));
  endtask

  // drive one cycle, push model expectation, pop and compare after the edge
  task automatic step(input string tag, input logic [3:0] ia, ib, iop, input logic iv);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = iv;
    model(ia, ib, iop, iv);
    q.push_back(m);
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk({tag, ".empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk_out(tag, e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".res"}, 32'(result), 32'd0);
    chk({tag, ".z"},   32'(zero), 32'd1);
    chk({tag, ".c"},   32'(carry), 32'd0);
    chk({tag, ".v"},   32'(overflow), 32'd0);
    chk({tag, ".ov"},  32'(out_valid), 32'd0);
  endtask

  // async reset landing between edges while a valid op is in flight
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    a = 4'($urandom); b = 4'($urandom); op = 4'b0010; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 chk_reset({tag, ".async"});
    @(posedge clk); #1;
    chk_reset({tag, ".hold"});
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    model_reset();
  endtask

  initial begin
    logic [3:0] ops[11];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
            4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b0101};
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk); rst = 1'b0;

    rst_pulse("rst0");
    step("idle", 4'd0, 4'd0, 4'd0, 1'b0);

    step("and", 4'd6, 4'd2, 4'b0000, 1'b1); chk("and.k", 32'(result), 32'd2);
    step("or",  4'd6, 4'd2, 4'b0001, 1'b1); chk("or.k",  32'(result), 32'd6);
    step("add", 4'd6, 4'd2, 4'b0010, 1'b1);
    chk("add.k", 32'({result, carry, overflow}), 32'({4'd8, 1'b0, 1'b1}));
    step("sub", 4'd6, 4'd2, 4'b0110, 1'b1);
    chk("sub.k", 32'({result, carry, overflow, zero}), 32'({4'd4, 1'b1, 1'b0, 1'b0}));
    step("slt_mn", 4'b1000, 4'd7, 4'b0111, 1'b1); chk("slt_mn.k", 32'(result), 32'd1);
    step("slt_eq", 4'd3, 4'd3, 4'b0111, 1'b1);    chk("slt_eq.k", 32'(result), 32'd0);
    step("sub_z", 4'd5, 4'd5, 4'b0110, 1'b1);
    chk("sub_z.k", 32'({result, zero, carry}), 32'({4'd0, 1'b1, 1'b1}));
    step("sll", 4'b1001, 4'd1, 4'b1000, 1'b1); chk("sll.k", 32'(result), 32'b0010);
    step("srl", 4'b1001, 4'd1, 4'b1001, 1'b1); chk("srl.k", 32'(result), 32'b0100);
    step("sra", 4'b1001, 4'd1, 4'b1010, 1'b1); chk("sra.k", 32'(result), 32'b1100);
    step("sll_m", 4'b0001, 4'b0111, 4'b1000, 1'b1); chk("sll_m.k", 32'(result), 32'b1000);
    step("undef", 4'd9, 4'd3, 4'b0101, 1'b1);
    chk("undef.k", 32'({result, zero}), 32'({4'd0, 1'b1}));
    step("sra2", 4'b1001, 4'd2, 4'b1010, 1'b1);
    step("drop", 4'd1, 4'd1, 4'b0010, 1'b0);
    chk("drop.k", 32'({result, out_valid}), 32'({4'b1110, 1'b0}));

    for (int i = 0; i < 1000; i++) begin
      if (i % 250 == 125) begin
        rst_pulse("rst_mid");
        step("post_rst", 4'($urandom), 4'($urandom), 4'b0010, 1'b0);
      end
      step("rand", 4'($urandom), 4'($urandom), ops[$urandom_range(10)],
           1'($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
